// File: rtl/vu_meter_ctrl.sv
// Windowed peak detector driving a thermometer LED bar and a peak-hold dot.
// Samples are accepted in ACCUM, the peak becomes a level in CALC, and the display is refreshed in UPD.
module vu_meter_ctrl #(
    parameter int DW       = 8,
    parameter int WIN_LEN  = 256,
    parameter int LEDS     = 8,
    parameter int HOLD_WIN = 4,
    localparam int LW      = $clog2(LEDS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            smp_valid,
    input  logic [DW-1:0]   smp_data,
    output logic            smp_ready,
    output logic [LW-1:0]   level,
    output logic [LEDS-1:0] bar,
    output logic [LEDS-1:0] peak_dot,
    output logic            upd
);

    localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int HW = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;
    localparam int PW = DW + LW;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CALC  = 2'd1,
        UPD   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] win_peak_q, win_peak_d;
    logic [LW-1:0] new_lvl_q, new_lvl_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] hold_lvl_q, hold_lvl_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          upd_q, upd_d;

    logic          accept;
    logic          last_smp;
    logic [PW-1:0] prod;

    assign smp_ready = en && (state_q == ACCUM);
    assign accept    = smp_valid && smp_ready;
    assign last_smp  = (cnt_q == CW'(WIN_LEN - 1));

    // Full-width product so the shift sees every bit; the result never exceeds LEDS.
    assign prod = PW'(win_peak_q) * PW'(LEDS + 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_peak_d = win_peak_q;
        new_lvl_d  = new_lvl_q;
        level_d    = level_q;
        hold_lvl_d = hold_lvl_q;
        hold_cnt_d = hold_cnt_q;
        upd_d      = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    win_peak_d = (smp_data > win_peak_q) ? smp_data : win_peak_q;
                    if (last_smp) begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CALC: begin
                new_lvl_d = LW'(prod >> DW);
                state_d   = UPD;
            end
            UPD: begin
                level_d    = new_lvl_q;
                win_peak_d = '0;
                upd_d      = 1'b1;
                // Peak dot: a new high reloads the hold time, otherwise hold, then fall one LED per window.
                if (new_lvl_q >= hold_lvl_q) begin
                    hold_lvl_d = new_lvl_q;
                    hold_cnt_d = HW'(HOLD_WIN);
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end else begin
                    hold_lvl_d = hold_lvl_q - LW'(1);
                end
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            win_peak_q <= '0;
            new_lvl_q  <= '0;
            level_q    <= '0;
            hold_lvl_q <= '0;
            hold_cnt_q <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_peak_q <= win_peak_d;
            new_lvl_q  <= new_lvl_d;
            level_q    <= level_d;
            hold_lvl_q <= hold_lvl_d;
            hold_cnt_q <= hold_cnt_d;
            upd_q      <= upd_d;
        end
    end

    // Display decode reads only registered state, so sample inputs never reach the LEDs.
    always_comb begin
        bar      = '0;
        peak_dot = '0;
        for (int i = 0; i < LEDS; i++) begin
            bar[i]      = (i < int'(level_q));
            peak_dot[i] = (int'(hold_lvl_q) == i + 1);
        end
    end

    assign level = level_q;
    assign upd   = upd_q;

endmodule

// File: tb/tb_vu_meter_ctrl.sv
// Directed bench for vu_meter_ctrl with a 4-sample window, 8 LEDs and a 2-window hold.
module tb_vu_meter_ctrl;

    localparam int DW       = 8;
    localparam int WIN_LEN  = 4;
    localparam int LEDS     = 8;
    localparam int HOLD_WIN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       smp_valid;
    logic [7:0] smp_data;
    logic       smp_ready;
    logic [3:0] level;
    logic [7:0] bar;
    logic [7:0] peak_dot;
    logic       upd;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int upd_lat;
    int rdy_low;
    logic upd_after;
    logic tmo;

    vu_meter_ctrl #(
        .DW(DW), .WIN_LEN(WIN_LEN), .LEDS(LEDS), .HOLD_WIN(HOLD_WIN)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .level(level), .bar(bar), .peak_dot(peak_dot), .upd(upd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Presents one sample from a falling edge and returns just after the rising edge that accepts it.
    task automatic send_sample(input logic [7:0] v);
        int n;
        n = 0;
        @(negedge clk);
        smp_valid = 1'b1;
        smp_data  = v;
        while (!smp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!smp_ready) tmo = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the last accept: records how many falling edges until upd and how long ready stays low.
    task automatic measure_upd();
        upd_lat = 0;
        rdy_low = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) smp_valid = 1'b0;
            if (upd) begin
                upd_lat = i;
                break;
            end
            if (!smp_ready) rdy_low++;
        end
        if (upd_lat == 0) tmo = 1'b1;
        @(negedge clk);
        upd_after = upd;
    endtask

    task automatic send_window(input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        tmo = 1'b0;
        send_sample(s0);
        send_sample(s1);
        send_sample(s2);
        send_sample(s3);
        measure_upd();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        en        = 1'b1;
        smp_valid = 1'b0;
        smp_data  = 8'h00;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (smp_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", smp_ready); else pass_cnt++;
        total_cnt++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (bar !== 8'h00) $display("FAIL reset_bar: got %h want 00", bar); else pass_cnt++;
        total_cnt++; if (peak_dot !== 8'h00) $display("FAIL reset_dot: got %h want 00", peak_dot); else pass_cnt++;
        total_cnt++; if (upd !== 1'b0) $display("FAIL reset_upd: got %b want 0", upd); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_level_map();
        logic [7:0] pk[4] = '{8'd28, 8'd29, 8'd200, 8'd255};
        logic [3:0] lv[4] = '{4'd0, 4'd1, 4'd7, 4'd8};
        logic [7:0] br[4] = '{8'h00, 8'h01, 8'h7F, 8'hFF};
        for (int w = 0; w < 4; w++) begin
            send_window(8'd0, pk[w], 8'd1, pk[w]);
            total_cnt++; if (tmo !== 1'b0) $display("FAIL map_timeout w%0d: got timeout want none", w); else pass_cnt++;
            total_cnt++; if (level !== lv[w]) $display("FAIL map_level w%0d: got %0d want %0d", w, level, lv[w]); else pass_cnt++;
            total_cnt++; if (bar !== br[w]) $display("FAIL map_bar w%0d: got %h want %h", w, bar, br[w]); else pass_cnt++;
            total_cnt++; if (upd_lat !== 3) $display("FAIL map_upd_latency w%0d: got %0d want 3", w, upd_lat); else pass_cnt++;
            total_cnt++; if (rdy_low !== 2) $display("FAIL map_ready_low w%0d: got %0d want 2", w, rdy_low); else pass_cnt++;
            total_cnt++; if (upd_after !== 1'b0) $display("FAIL map_upd_width w%0d: got %b want 0", w, upd_after); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        tmo = 1'b0;
        send_sample(8'd255);
        send_sample(8'd255);
        @(negedge clk);
        smp_valid = 1'b0;
        rst       = 1'b0;
        #1;
        total_cnt++; if (level !== 4'd0) $display("FAIL midrst_level: got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (bar !== 8'h00) $display("FAIL midrst_bar: got %h want 00", bar); else pass_cnt++;
        total_cnt++; if (peak_dot !== 8'h00) $display("FAIL midrst_dot: got %h want 00", peak_dot); else pass_cnt++;
        total_cnt++; if (upd !== 1'b0) $display("FAIL midrst_upd: got %b want 0", upd); else pass_cnt++;
        total_cnt++; if (smp_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", smp_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        send_window(8'd29, 8'd29, 8'd29, 8'd29);
        total_cnt++; if (tmo !== 1'b0) $display("FAIL midrst_timeout: got timeout want none"); else pass_cnt++;
        total_cnt++; if (upd_lat !== 3) $display("FAIL midrst_latency: got %0d want 3", upd_lat); else pass_cnt++;
        total_cnt++; if (level !== 4'd1) $display("FAIL midrst_new_level: got %0d want 1", level); else pass_cnt++;
        total_cnt++; if (peak_dot !== 8'h01) $display("FAIL midrst_new_dot: got %h want 01", peak_dot); else pass_cnt++;
    endtask

    task automatic test_max_window();
        send_window(8'd10, 8'd250, 8'd3, 8'd40);
        total_cnt++; if (level !== 4'd8) $display("FAIL max_level: got %0d want 8", level); else pass_cnt++;
        total_cnt++; if (bar !== 8'hFF) $display("FAIL max_bar: got %h want ff", bar); else pass_cnt++;
        send_window(8'd5, 8'd5, 8'd5, 8'd5);
        total_cnt++; if (level !== 4'd0) $display("FAIL max_cleared_level: got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (bar !== 8'h00) $display("FAIL max_cleared_bar: got %h want 00", bar); else pass_cnt++;
    endtask

    task automatic test_peak_hold();
        logic [7:0] exp_dot[10] = '{8'h80, 8'h80, 8'h40, 8'h20, 8'h10,
                                    8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
        send_window(8'd255, 8'd0, 8'd0, 8'd0);
        total_cnt++; if (peak_dot !== 8'h80) $display("FAIL hold_start_dot: got %h want 80", peak_dot); else pass_cnt++;
        for (int w = 0; w < 10; w++) begin
            send_window(8'd0, 8'd0, 8'd0, 8'd0);
            total_cnt++; if (peak_dot !== exp_dot[w]) $display("FAIL hold_decay_dot w%0d: got %h want %h", w, peak_dot, exp_dot[w]); else pass_cnt++;
            total_cnt++; if (bar !== 8'h00) $display("FAIL hold_decay_bar w%0d: got %h want 00", w, bar); else pass_cnt++;
        end
    endtask

    task automatic test_hold_refresh();
        logic [7:0] pk[3]   = '{8'd150, 8'd90, 8'd180};
        logic [3:0] lv[3]   = '{4'd5, 4'd3, 4'd6};
        logic [7:0] dot[3]  = '{8'h10, 8'h10, 8'h20};
        logic [7:0] tail[3] = '{8'h20, 8'h20, 8'h10};
        for (int w = 0; w < 3; w++) begin
            send_window(pk[w], pk[w], pk[w], pk[w]);
            total_cnt++; if (level !== lv[w]) $display("FAIL refresh_level w%0d: got %0d want %0d", w, level, lv[w]); else pass_cnt++;
            total_cnt++; if (peak_dot !== dot[w]) $display("FAIL refresh_dot w%0d: got %h want %h", w, peak_dot, dot[w]); else pass_cnt++;
        end
        for (int w = 0; w < 3; w++) begin
            send_window(8'd0, 8'd0, 8'd0, 8'd0);
            total_cnt++; if (peak_dot !== tail[w]) $display("FAIL refresh_reload_dot w%0d: got %h want %h", w, peak_dot, tail[w]); else pass_cnt++;
        end
    endtask

    task automatic test_handshake_en();
        logic [7:0] d[4] = '{8'd20, 8'd100, 8'd60, 8'd30};
        int   acc        = 0;
        int   cyc        = 0;
        int   bad_rdy    = 0;
        int   early_upd  = 0;
        logic dropped    = 1'b0;
        logic v;
        logic seen;
        tmo = 1'b0;
        while (acc < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (upd) early_upd++;
            if (acc == 2 && !dropped) begin
                dropped   = 1'b1;
                en        = 1'b0;
                smp_valid = 1'b1;
                smp_data  = 8'hFF;
                for (int i = 0; i < 10; i++) begin
                    #1;
                    if (smp_ready) bad_rdy++;
                    @(negedge clk);
                end
                en = 1'b1;
            end
            v         = 1'($urandom_range(0, 1));
            smp_valid = v;
            smp_data  = v ? d[acc] : 8'hFF;
            #1;
            if (v && smp_ready) begin
                @(posedge clk);
                acc++;
            end
        end
        if (acc < 4) tmo = 1'b1;
        measure_upd();
        total_cnt++; if (tmo !== 1'b0) $display("FAIL hs_timeout: got timeout want none"); else pass_cnt++;
        total_cnt++; if (bad_rdy !== 0) $display("FAIL hs_ready_while_en_low: got %0d want 0", bad_rdy); else pass_cnt++;
        total_cnt++; if (early_upd !== 0) $display("FAIL hs_early_upd: got %0d want 0", early_upd); else pass_cnt++;
        total_cnt++; if (upd_lat !== 3) $display("FAIL hs_latency: got %0d want 3", upd_lat); else pass_cnt++;
        total_cnt++; if (level !== 4'd3) $display("FAIL hs_level: got %0d want 3", level); else pass_cnt++;
        total_cnt++; if (bar !== 8'h07) $display("FAIL hs_bar: got %h want 07", bar); else pass_cnt++;

        // Drop en while the window is being converted; the refresh must still happen.
        send_sample(8'd200);
        send_sample(8'd200);
        send_sample(8'd200);
        send_sample(8'd200);
        @(negedge clk);
        en        = 1'b0;
        smp_valid = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++; if (seen !== 1'b1) $display("FAIL en_calc_upd: got %b want 1", seen); else pass_cnt++;
        total_cnt++; if (level !== 4'd7) $display("FAIL en_calc_level: got %0d want 7", level); else pass_cnt++;
        total_cnt++; if (smp_ready !== 1'b0) $display("FAIL en_calc_parked_ready: got %b want 0", smp_ready); else pass_cnt++;
        en = 1'b1;
        #1;
        total_cnt++; if (smp_ready !== 1'b1) $display("FAIL en_resume_ready: got %b want 1", smp_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_level_map();
        test_reset_mid();
        test_max_window();
        test_peak_hold();
        test_hold_refresh();
        test_handshake_en();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vu_meter_ctrl.md
# vu_meter_ctrl

Windowed peak-detect and display controller for the VU meter LED bar. It accepts unsigned sample magnitudes over a valid/ready handshake and tracks the maximum over a fixed window of samples. At each window end it converts the peak to a bar level and updates a thermometer-coded LED bar plus a peak-hold dot that holds and then decays. It sits between the sample front end and the LED drivers, and it sequences all display refresh timing.

## Interface
- DW, 8: sample magnitude width (unsigned).
- WIN_LEN, 256: accepted samples per window, ≥2.
- LEDS, 8: number of LEDs in the bar.
- HOLD_WIN, 4: windows the peak dot holds before decaying, ≥0.
- LW: derived, clog2(LEDS+1); width of the level.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  enable sample acceptance.
- smp_valid  input  1  sample present.
- smp_data  input  DW  sample magnitude.
- smp_ready  output  1  controller accepts a sample this cycle.
- level  output  LW  current bar level, 0..LEDS.
- bar  output  LEDS  thermometer bar: bits [level-1:0] set.
- peak_dot  output  LEDS  one-hot at bit hold_lvl-1; all zero when hold_lvl=0.
- upd  output  1  one-cycle pulse when the outputs change to a new window result.

## Operation
- FSM states:
  - ACCUM: collecting samples.
  - CALC: convert the window peak to a level.
  - UPD: update the display and peak hold.
- FSM transitions:
  - ACCUM→CALC on the last accepted sample of the window.
  - CALC→UPD unconditionally.
  - UPD→ACCUM unconditionally.
- smp_ready = en && state==ACCUM; it is combinational from the state register and en. A sample is accepted when smp_valid && smp_ready.
- Sample counter:
  - 0..WIN_LEN-1, increments on each accepted sample.
  - Wraps to 0 on the accept at WIN_LEN-1, which also triggers ACCUM→CALC.
- Window peak:
  - win_peak <= max(win_peak, smp_data) on each accept, so the last sample is included.
  - Cleared to 0 in UPD.
- CALC: new_lvl <= (win_peak*(LEDS+1)) >> DW. The product is computed at DW+LW bits with no truncation before the shift. The result is ≤LEDS by construction.
- UPD, peak-hold update:
  - If new_lvl ≥ hold_lvl: hold_lvl <= new_lvl and hold_cnt <= HOLD_WIN.
  - Else if hold_cnt≠0: hold_cnt <= hold_cnt-1.
  - Else: hold_lvl <= hold_lvl-1. No underflow is possible, since hold_lvl > new_lvl ≥ 0.
- UPD, outputs: level <= new_lvl; bar and peak_dot are recomputed from the registered level/hold_lvl; upd <= 1.
- en low:
  - In ACCUM: no accepts; the counter and win_peak hold.
  - In CALC/UPD: the sequence completes normally and the FSM then parks in ACCUM.
  - A partial window resumes when en returns.
- Reset values: state=ACCUM; counter, win_peak, new_lvl, level, hold_lvl and hold_cnt all 0; bar=0, peak_dot=0, upd=0.
- Reset mid-window discards the partial window. Outputs return to 0 immediately (asynchronous).

## Timing
- The last sample of the window is accepted at edge k:
  - state=CALC after k.
  - new_lvl is registered at k+1; state=UPD.
  - level, bar, hold_lvl and peak_dot are updated at k+2; upd=1 for exactly the cycle following k+2.
- The state returns to ACCUM after k+2, so smp_ready is low for exactly 2 cycles per window (when en=1).
- Window-to-display latency: 2 clocks from the last accept to the new outputs.
- bar and peak_dot are registered, or decoded combinationally from registered level/hold_lvl only. There is no path from smp_* to the display outputs.
- The peak dot decays by at most one LED per window. A full hold-then-fall from LEDS to 0 takes HOLD_WIN+LEDS windows with zero input.

## Test plan
All scenarios use WIN_LEN=4, LEDS=8, DW=8, HOLD_WIN=2 unless noted.

1. **Reset.** Assert rst low mid-window → smp_ready=en, level=0, bar=0x00, peak_dot=0x00, upd=0. The next window starts at count 0.
2. **Level mapping.** Windows with peaks 28, 29, 200, 255 → level 0, 1, 7, 8 respectively.
   - bar: 0x00, 0x01, 0x7F, 0xFF.
   - upd pulses once per window, 2 cycles after the 4th accept.
   - smp_ready is low for those 2 cycles.
3. **Max over window.** Samples 10, 250, 3, 40 → level 8. The next window 5, 5, 5, 5 starts from win_peak=0 → level 0.
4. **Peak hold and decay.** One window at 255, then zero windows:
   - peak_dot stays 0x80 for the next 2 windows.
   - It then steps through 0x40, 0x20 … 0x01, then 0x00, one step per window.
   - bar=0x00 throughout the zero windows.
5. **Hold refresh.** Level 5, then 3, then 6 → peak_dot 0x10, 0x10, 0x20, with hold_cnt reloaded on the level-6 window.
6. **Handshake and en.** smp_valid toggled randomly and en dropped for 10 cycles mid-window:
   - Only accepted samples are counted.
   - No accepts while en=0.
   - The window completes after exactly 4 accepts.
   - Dropping en during CALC still yields upd.
